// File: rtl/nn_dataset_mem.sv
// Dataset memory responder: host streams a header+sample image into RAM, then the processor reads it back.
// Latency: a write is stored on the accepting edge; a read returns mem_data/mem_valid one clock after rd_en.
// Backpressure: host_ready drops while the header is sized, once loaded and on error; reads are never stalled.
module nn_dataset_mem #(
    parameter int DEPTH            = 256,
    parameter int ADDR_W           = 8,
    parameter int WORDS_PER_SAMPLE = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soft_clear,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_data,
    input  logic        host_last,
    output logic        load_done,
    output logic        load_error,
    output logic [7:0]  num_train,
    output logic [7:0]  num_test,
    input  logic        rd_en,
    input  logic [31:0] address,
    output logic [31:0] mem_data,
    output logic        mem_valid,
    output logic        last_train,
    output logic        last_test,
    output logic        addr_err
);

    // Image sizes are tracked at 12 bits: the largest header (255+255 samples) still fits.
    localparam int          CNT_W   = 12;
    localparam int          PAD_W   = 32 - CNT_W;
    localparam logic [11:0] WPS     = 12'(WORDS_PER_SAMPLE);
    localparam logic [11:0] DEPTH_T = 12'(DEPTH);

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_SIZE,
        ST_BODY,
        ST_READY,
        ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]         num_train_q, num_train_d;
    logic [7:0]         num_test_q, num_test_d;
    logic [CNT_W-1:0]   total_q, total_d;

    logic [31:0]        mem_data_q, mem_data_d;
    logic               mem_valid_q, mem_valid_d;
    logic               last_train_q, last_train_d;
    logic               last_test_q, last_test_d;
    logic               addr_err_q, addr_err_d;

    logic [31:0]        ram [DEPTH];

    logic               host_ready_int;
    logic               accept;
    logic               wr_en;
    logic [CNT_W-1:0]   total_hdr;
    logic [CNT_W-1:0]   train_end;
    logic [CNT_W-1:0]   test_end;
    logic               rd_fire;
    logic               in_range;

    // Host may push words only while the image is still being collected.
    always_comb begin
        host_ready_int = 1'b0;
        case (state_q)
            ST_HDR0, ST_HDR1, ST_BODY: host_ready_int = 1'b1;
            default:                   host_ready_int = 1'b0;
        endcase
    end

    // Held low during reset so every output reads 0 while rst is asserted.
    assign host_ready = host_ready_int & ~rst;
    assign accept     = host_valid & host_ready_int;
    // A word arriving together with soft_clear is dropped.
    assign wr_en      = accept & ~soft_clear;

    // Image length computed from the latched num_train and the num_test word on the bus.
    assign total_hdr = 12'd2 + WPS * ({4'b0, num_train_q} + {4'b0, host_data[7:0]});
    assign train_end = 12'd1 + WPS * {4'b0, num_train_q};
    assign test_end  = total_q - 12'd1;

    // Load FSM: next state, write pointer and header registers; soft_clear wins over everything.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        num_train_d = num_train_q;
        num_test_d  = num_test_q;
        total_d     = total_q;
        if (soft_clear) begin
            state_d     = ST_HDR0;
            wr_ptr_d    = '0;
            num_train_d = '0;
            num_test_d  = '0;
            total_d     = '0;
        end else begin
            case (state_q)
                ST_HDR0: begin
                    if (accept) begin
                        num_train_d = host_data[7:0];
                        wr_ptr_d    = wr_ptr_q + 12'd1;
                        state_d     = host_last ? ST_ERROR : ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (accept) begin
                        num_test_d = host_data[7:0];
                        total_d    = total_hdr;
                        wr_ptr_d   = wr_ptr_q + 12'd1;
                        // host_last is legal here only when the header is the whole image.
                        state_d    = (host_last && (total_hdr != 12'd2)) ? ST_ERROR : ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (total_q > DEPTH_T) begin
                        state_d = ST_ERROR;
                    end else if (total_q == 12'd2) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        wr_ptr_d = wr_ptr_q + 12'd1;
                        if (wr_ptr_q == test_end) begin
                            state_d = ST_READY;
                        end else if (host_last) begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Load FSM and header registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR0;
            wr_ptr_q    <= '0;
            num_train_q <= '0;
            num_test_q  <= '0;
            total_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            num_train_q <= num_train_d;
            num_test_q  <= num_test_d;
            total_q     <= total_d;
        end
    end

    // Image storage; contents are don't-care after reset so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr_q[ADDR_W-1:0]] <= host_data;
        end
    end

    // Reads only count once the image is complete; a read issued on a soft_clear edge still returns.
    assign rd_fire  = rd_en & (state_q == ST_READY);
    assign in_range = address < {{PAD_W{1'b0}}, total_q};

    // Read response: data plus end-of-region flags, or a zeroed out-of-range error; data holds when idle.
    always_comb begin
        mem_data_d   = mem_data_q;
        mem_valid_d  = 1'b0;
        last_train_d = 1'b0;
        last_test_d  = 1'b0;
        addr_err_d   = 1'b0;
        if (rd_fire) begin
            mem_valid_d = 1'b1;
            if (in_range) begin
                mem_data_d   = ram[address[ADDR_W-1:0]];
                last_train_d = (address == {{PAD_W{1'b0}}, train_end}) && (num_train_q != 8'd0);
                last_test_d  = (address == {{PAD_W{1'b0}}, test_end}) && (num_test_q != 8'd0);
            end else begin
                mem_data_d = '0;
                addr_err_d = 1'b1;
            end
        end
    end

    // Registered read port: no combinational path from address to mem_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_q   <= '0;
            mem_valid_q  <= 1'b0;
            last_train_q <= 1'b0;
            last_test_q  <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            mem_data_q   <= mem_data_d;
            mem_valid_q  <= mem_valid_d;
            last_train_q <= last_train_d;
            last_test_q  <= last_test_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign load_done  = (state_q == ST_READY);
    assign load_error = (state_q == ST_ERROR);
    assign num_train  = num_train_q;
    assign num_test   = num_test_q;
    assign mem_data   = mem_data_q;
    assign mem_valid  = mem_valid_q;
    assign last_train = last_train_q;
    assign last_test  = last_test_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_nn_dataset_mem.sv
// Bench for nn_dataset_mem: loads images over the host port and reads them back.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Expected read results come from the image held in the bench and the layout rules.
module tb_nn_dataset_mem;

    logic        clk;
    logic        rst;
    logic        soft_clear;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_data;
    logic        host_last;
    logic        load_done;
    logic        load_error;
    logic [7:0]  num_train;
    logic [7:0]  num_test;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        last_train;
    logic        last_test;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference image and its header-derived sizes.
    logic [31:0] m_img [0:255];
    int          m_nt;
    int          m_nf;
    int          m_total;
    logic [31:0] m_last_data;

    logic [31:0] rq_a [$];
    bit          rq_e [$];

    nn_dataset_mem #(
        .DEPTH(256),
        .ADDR_W(8),
        .WORDS_PER_SAMPLE(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .soft_clear(soft_clear),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_data(host_data),
        .host_last(host_last),
        .load_done(load_done),
        .load_error(load_error),
        .num_train(num_train),
        .num_test(num_test),
        .rd_en(rd_en),
        .address(address),
        .mem_data(mem_data),
        .mem_valid(mem_valid),
        .last_train(last_train),
        .last_test(last_test),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        soft_clear = 1'b0;
        host_valid = 1'b0;
        host_last  = 1'b0;
        host_data  = '0;
        rd_en      = 1'b0;
        address    = '0;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        m_last_data = '0;
        @(negedge clk);
    endtask

    // Offer one word and wait (bounded) for the block to take it.
    task automatic push(input logic [31:0] w, input bit l, output bit ok);
        ok         = 1'b0;
        host_valid = 1'b1;
        host_data  = w;
        host_last  = l;
        for (int k = 0; k < 16 && !ok; k++) begin
            if (host_ready) ok = 1'b1;
            @(negedge clk);
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    // Build an image, then stream it; err_at marks an early host_last, upto stops a partial load.
    task automatic load_image(input int nt, input int nf, input int err_at, input int upto,
                              input bit gaps, input bit hi_zero);
        int          n;
        bit          ok;
        bit          lst;
        logic [31:0] w;
        m_nt    = nt;
        m_nf    = nf;
        m_total = 2 + 5 * (nt + nf);
        for (int i = 0; i < m_total && i < 256; i++) begin
            w = hi_zero ? 32'h0 : $urandom();
            if (i == 0) w[7:0] = nt[7:0];
            if (i == 1) w[7:0] = nf[7:0];
            m_img[i] = w;
        end
        n = (upto < 0) ? m_total : upto;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) @(negedge clk);
            chk("done_early", load_done, 0);
            lst = (i == err_at) || ((i == m_total - 1) && ($urandom_range(0, 1) == 1));
            push(m_img[i], lst, ok);
            chk("host_acc", ok, 1);
            if (!ok || i == err_at) return;
        end
        if (upto >= 0) return;
        if (m_total > 2) begin
            chk("done_imm", load_done, 1);
            chk("ready_drop", host_ready, 0);
        end else begin
            chk("size_cyc", load_done, 0);
            chk("size_rdy", host_ready, 0);
            @(negedge clk);
            chk("done_size", load_done, 1);
        end
        chk("num_train", num_train, nt);
        chk("num_test", num_test, nf);
        chk("load_err", load_error, 0);
    endtask

    // Expected response for one sampled read, from the image layout rules.
    task automatic check_read(input logic [31:0] a, input bit en);
        logic [31:0] ed;
        bit          elt, els, eae;
        ed  = m_last_data;
        elt = 1'b0;
        els = 1'b0;
        eae = 1'b0;
        if (en) begin
            if (a >= m_total) begin
                ed  = '0;
                eae = 1'b1;
            end else begin
                ed  = m_img[a[7:0]];
                elt = (a == 1 + 5 * m_nt) && (m_nt != 0);
                els = (a == m_total - 1) && (m_nf != 0);
            end
        end
        chk("rd_valid", mem_valid, en);
        chk("rd_data", mem_data, ed);
        chk("rd_last_train", last_train, elt);
        chk("rd_last_test", last_test, els);
        chk("rd_addr_err", addr_err, eae);
        m_last_data = ed;
    endtask

    // Back-to-back reads from the queued list, each checked one clock later.
    task automatic run_reads(input bit live);
        foreach (rq_a[i]) begin
            rd_en   = rq_e[i];
            address = rq_a[i];
            @(negedge clk);
            check_read(rq_a[i], rq_e[i] && live);
        end
        rd_en = 1'b0;
        rq_a.delete();
        rq_e.delete();
    endtask

    task automatic queue_rd(input logic [31:0] a, input bit e);
        rq_a.push_back(a);
        rq_e.push_back(e);
    endtask

    initial begin
        bit          ok;
        int          cnt;
        int          sel;
        logic [31:0] a;

        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_host_ready", host_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_num_train", num_train, 0);
        chk("rst_num_test", num_test, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_flags", {last_train, last_test, addr_err}, 0);
        do_reset();
        chk("post_rst_ready", host_ready, 1);

        // 2 training + 1 test sample, full sequential readback.
        load_image(2, 1, -1, -1, 0, 0);
        for (int i = 0; i < 17; i++) queue_rd(i, 1);
        queue_rd(32'd0, 0);
        run_reads(1);

        // Early host_last on word 9 of a 17-word image.
        do_reset();
        load_image(2, 1, 9, -1, 0, 0);
        chk("err_load_error", load_error, 1);
        chk("err_host_ready", host_ready, 0);
        chk("err_num_train", num_train, 2);
        queue_rd(32'd3, 1);
        queue_rd(32'd4, 1);
        run_reads(0);
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        chk("clr_num_train", num_train, 0);
        chk("clr_load_error", load_error, 0);
        chk("clr_host_ready", host_ready, 1);

        // Oversized header: 30/30 gives 302 words.
        do_reset();
        push(32'd30, 1'b0, ok);
        chk("big_hdr0", ok, 1);
        push(32'd30, 1'b0, ok);
        chk("big_hdr1", ok, 1);
        chk("big_size_err", load_error, 0);
        chk("big_size_rdy", host_ready, 0);
        cnt        = 0;
        host_valid = 1'b1;
        host_data  = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            if (host_ready) cnt++;
            @(negedge clk);
        end
        host_valid = 1'b0;
        chk("big_body_acc", cnt, 0);
        chk("big_load_error", load_error, 1);
        chk("big_load_done", load_done, 0);

        // Empty dataset: header only.
        do_reset();
        load_image(0, 0, -1, -1, 0, 1);
        queue_rd(32'd1, 1);
        queue_rd(32'd2, 1);
        queue_rd(32'd0, 1);
        queue_rd(32'h0000_0100, 1);
        queue_rd(32'hFFFF_FFFF, 1);
        run_reads(1);

        // Gapped load cut by soft_clear alongside an accepted word, then a clean reload.
        do_reset();
        load_image(1, 1, -1, 6, 1, 0);
        chk("gap_ready", host_ready, 1);
        host_valid = 1'b1;
        host_data  = 32'hDEAD_BEEF;
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        host_valid = 1'b0;
        chk("sc_num_train", num_train, 0);
        chk("sc_host_ready", host_ready, 1);
        chk("sc_load_done", load_done, 0);
        load_image(1, 1, -1, -1, 1, 0);
        for (int i = 0; i < 13; i++) queue_rd(i, 1);
        run_reads(1);
        // Read in flight across soft_clear returns; the next one is ignored.
        rd_en      = 1'b1;
        address    = 32'd5;
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        check_read(32'd5, 1);
        @(negedge clk);
        check_read(32'd5, 0);
        rd_en = 1'b0;
        chk("sc_rd_done", load_done, 0);

        // Asynchronous reset in the middle of the body.
        do_reset();
        load_image(3, 2, -1, 8, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_host_ready", host_ready, 0);
        chk("arst_num_train", num_train, 0);
        chk("arst_load_done", load_done, 0);
        chk("arst_mem_valid", mem_valid, 0);
        @(negedge clk);
        rst         = 1'b0;
        m_last_data = '0;
        @(negedge clk);
        chk("arst_rel_num_train", num_train, 0);
        chk("arst_rel_ready", host_ready, 1);
        load_image(3, 2, -1, -1, 0, 0);
        for (int i = 0; i < 27; i++) queue_rd(i, 1);
        run_reads(1);

        // Randomized images and read streams.
        for (int it = 0; it < 4; it++) begin
            int nt;
            int nf;
            do_reset();
            nt = $urandom_range(0, 25);
            nf = $urandom_range(0, 50 - nt);
            load_image(nt, nf, -1, -1, $urandom_range(0, 1) == 1, 0);
            for (int k = 0; k < 40; k++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0:       a = 1 + 5 * m_nt;
                    1:       a = m_total - 1;
                    2:       a = m_total;
                    3:       a = $urandom();
                    default: a = $urandom_range(0, m_total + 2);
                endcase
                queue_rd(a, $urandom_range(0, 3) != 0);
            end
            run_reads(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
